player_bullet: RTL and testbench
================================

Name: player_bullet

Overview:
- Downstream of the player ship FSM; consumes the shoot button and the ship's left/right position.
- Launches a single player bullet from the ship's centre and moves it upward once per frame tick.
- Retires the bullet on an enemy hit or when it reaches the top border, then enforces a frame-counted cooldown.
- Outputs drive the VGA sprite renderer and the enemy-grid collision logic.

Parameters:
- speed_p, 4: pixels the bullet moves up per frame tick.
- start_y_p, 440: bullet y loaded at fire (ship top row).
- top_y_p, 8: top border y; the bullet is retired at or above it.
- cooldown_p, 15: frame ticks after retirement before the next fire is allowed (0 allowed).

Ports:
- clk_i  input  1  pixel/system clock.
- reset_n_i  input  1  asynchronous, active-low reset.
- frame_tick_i  input  1  one-cycle pulse per video frame.
- shoot_i  input  1  shoot button, debounced, level.
- pause_i  input  1  level frozen (player shot and alive); freezes the block.
- alive_i  input  1  player alive; low forces the bullet off.
- pos_left_i  input  10  ship leftmost x.
- pos_right_i  input  10  ship rightmost x.
- target_hit_i  input  1  enemy grid reports the bullet collided this cycle.
- bullet_active_o  output  1  bullet on screen.
- bullet_x_o  output  10  bullet x (held constant in flight).
- bullet_y_o  output  9  bullet y.
- fired_o  output  1  one-cycle pulse on launch.
- miss_o  output  1  one-cycle pulse when the bullet leaves through the top.
- state_o  output  3  present one-hot state, for debug.

Behaviour:
- States are one-hot: IDLE=001, FLYING=010, COOLDOWN=100.
- Reset values: state IDLE; bullet_active_o=0; bullet_x_o=0; bullet_y_o=start_y_p; fired_o=0; miss_o=0; cooldown counter=0.
- Edge-detect register shoot_q resets to 1, so a button held through reset does not fire.
- Fire = shoot_i & ~shoot_q. shoot_q samples shoot_i every cycle, including during pause.
- IDLE -> FLYING when fire & alive_i & ~pause_i. On that edge:
  - bullet_x_o <= (pos_left_i + pos_right_i) >> 1, computed in 11 bits and truncated to 10.
  - bullet_y_o <= start_y_p.
  - bullet_active_o <= 1.
  - fired_o is 1 for exactly the first FLYING cycle (1-cycle latency from the edge).
- Fire requests in FLYING or COOLDOWN are dropped, not queued.
- FLYING, evaluated in this priority order:
  1. target_hit_i -> COOLDOWN; bullet_active_o <= 0; no miss_o.
  2. On frame_tick_i with bullet_y_o <= top_y_p + speed_p -> COOLDOWN; bullet_active_o <= 0; miss_o pulses 1 cycle.
  3. On frame_tick_i otherwise: bullet_y_o <= bullet_y_o - speed_p. This never underflows because of rule 2.
  - target_hit_i and frame_tick_i in the same cycle: hit wins, no miss.
- COOLDOWN:
  - Counter loads 0 on entry and increments on each frame_tick_i.
  - When the counter reaches cooldown_p -> IDLE.
  - If cooldown_p=0, COOLDOWN lasts exactly one cycle.
- pause_i=1 freezes state, position and counter; frame_tick_i and target_hit_i are ignored; outputs hold. Resuming continues from the held values.
- alive_i=0 (synchronous) from any state -> IDLE next cycle: bullet_active_o=0, counter cleared, no miss_o. This takes priority over everything except reset.
- Async reset mid-flight clears immediately to the reset values.
- bullet_x_o and bullet_y_o keep their last values while inactive; the renderer must gate on bullet_active_o.

Test Plan:
- Reset with shoot_i=1 held, release, press again -> no fire during hold; fired_o=1 one cycle after the second press; bullet_x_o=(100+131)>>1=115 for pos 100/131; bullet_y_o=440.
- Fire, then issue 107 frame ticks -> bullet_y_o steps 440, 436, …, 12. The tick at y=12 gives miss_o=1 for one cycle and bullet_active_o=0. After 15 further ticks state_o=001.
- Fire, then pulse target_hit_i together with frame_tick_i at y=300 -> bullet_active_o=0 next cycle, miss_o stays 0, state_o=100.
- Hold shoot_i high during FLYING and COOLDOWN -> no second fired_o. A fresh press after return to IDLE fires.
- In flight at y=200, raise pause_i for 10 ticks plus a target_hit_i pulse -> y stays 200, bullet still active. After pause_i drops, the next tick gives y=196.
- Drop alive_i during FLYING and during COOLDOWN -> state_o=001 next cycle, bullet_active_o=0, miss_o=0. A fire with alive_i=0 is ignored.

Source files
------------

// File: rtl/player_bullet.sv
// Single player bullet: launched from the ship centre on a shoot edge, climbs once per frame,
// retires on hit or at the top border, then waits a frame-counted cooldown before re-arming.
module player_bullet #(
    parameter int unsigned speed_p    = 4,
    parameter int unsigned start_y_p  = 440,
    parameter int unsigned top_y_p    = 8,
    parameter int unsigned cooldown_p = 15
) (
    input  logic       clk_i,
    input  logic       reset_n_i,
    input  logic       frame_tick_i,
    input  logic       shoot_i,
    input  logic       pause_i,
    input  logic       alive_i,
    input  logic [9:0] pos_left_i,
    input  logic [9:0] pos_right_i,
    input  logic       target_hit_i,
    output logic       bullet_active_o,
    output logic [9:0] bullet_x_o,
    output logic [8:0] bullet_y_o,
    output logic       fired_o,
    output logic       miss_o,
    output logic [2:0] state_o
);

    localparam int CNT_W = (cooldown_p < 1) ? 1 : $clog2(cooldown_p + 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(cooldown_p);
    localparam logic [8:0]       START_Y  = 9'(start_y_p);
    localparam logic [8:0]       SPEED    = 9'(speed_p);
    localparam logic [9:0]       RETIRE_Y = 10'(top_y_p + speed_p);

    typedef enum logic [2:0] {
        ST_IDLE     = 3'b001,
        ST_FLYING   = 3'b010,
        ST_COOLDOWN = 3'b100
    } state_e;

    state_e           state_q, state_d;
    logic             active_q, active_d;
    logic [9:0]       x_q, x_d;
    logic [8:0]       y_q, y_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             fired_q, fired_d;
    logic             miss_q, miss_d;
    logic             shoot_q;
    logic             fire;

    assign fire = shoot_i & ~shoot_q;

    always_comb begin
        state_d  = state_q;
        active_d = active_q;
        x_d      = x_q;
        y_d      = y_q;
        cnt_d    = cnt_q;
        fired_d  = 1'b0;
        miss_d   = 1'b0;
        if (!alive_i) begin
            state_d  = ST_IDLE;
            active_d = 1'b0;
            cnt_d    = '0;
        end else if (!pause_i) begin
            unique case (state_q)
                ST_IDLE: begin
                    if (fire) begin
                        state_d  = ST_FLYING;
                        // Sum needs the carry bit before halving
                        x_d      = 10'(({1'b0, pos_left_i} + {1'b0, pos_right_i}) >> 1);
                        y_d      = START_Y;
                        active_d = 1'b1;
                        fired_d  = 1'b1;
                    end
                end
                ST_FLYING: begin
                    if (target_hit_i) begin
                        state_d  = ST_COOLDOWN;
                        active_d = 1'b0;
                        cnt_d    = '0;
                    end else if (frame_tick_i) begin
                        if ({1'b0, y_q} <= RETIRE_Y) begin
                            state_d  = ST_COOLDOWN;
                            active_d = 1'b0;
                            miss_d   = 1'b1;
                            cnt_d    = '0;
                        end else begin
                            y_d = y_q - SPEED;
                        end
                    end
                end
                ST_COOLDOWN: begin
                    if (cnt_q == CNT_MAX) state_d = ST_IDLE;
                    else if (frame_tick_i) cnt_d = cnt_q + 1'b1;
                end
                default: begin
                    state_d  = ST_IDLE;
                    active_d = 1'b0;
                    cnt_d    = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q  <= ST_IDLE;
            active_q <= 1'b0;
            x_q      <= '0;
            y_q      <= START_Y;
            cnt_q    <= '0;
            fired_q  <= 1'b0;
            miss_q   <= 1'b0;
            // A button held through reset must not register as a press
            shoot_q  <= 1'b1;
        end else begin
            state_q  <= state_d;
            active_q <= active_d;
            x_q      <= x_d;
            y_q      <= y_d;
            cnt_q    <= cnt_d;
            fired_q  <= fired_d;
            miss_q   <= miss_d;
            shoot_q  <= shoot_i;
        end
    end

    assign bullet_active_o = active_q;
    assign bullet_x_o      = x_q;
    assign bullet_y_o      = y_q;
    assign fired_o         = fired_q;
    assign miss_o          = miss_q;
    assign state_o         = state_q;

endmodule

// File: tb/tb_player_bullet.sv
// Scoreboard bench for player_bullet: launch/miss events are queued as stimulus is driven
// and matched by a monitor; each scenario task also checks state and position inline.
module tb_player_bullet;

    logic       clk_i = 1'b0;
    logic       reset_n_i, frame_tick_i, shoot_i, pause_i, alive_i, target_hit_i;
    logic [9:0] pos_left_i, pos_right_i;
    logic       bullet_active_o, fired_o, miss_o;
    logic [9:0] bullet_x_o;
    logic [8:0] bullet_y_o;
    logic [2:0] state_o;

    player_bullet dut (
        .clk_i(clk_i), .reset_n_i(reset_n_i), .frame_tick_i(frame_tick_i),
        .shoot_i(shoot_i), .pause_i(pause_i), .alive_i(alive_i),
        .pos_left_i(pos_left_i), .pos_right_i(pos_right_i), .target_hit_i(target_hit_i),
        .bullet_active_o(bullet_active_o), .bullet_x_o(bullet_x_o), .bullet_y_o(bullet_y_o),
        .fired_o(fired_o), .miss_o(miss_o), .state_o(state_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic       is_miss;
        logic [9:0] x;
        logic [8:0] y;
    } ev_t;

    ev_t exp_q[$];
    ev_t ev_mon;
    int  n_checks = 0;
    int  n_fail   = 0;
    int  exp_y;
    logic [9:0] exp_x;

    localparam logic [2:0] S_IDLE = 3'b001, S_FLY = 3'b010, S_COOL = 3'b100;

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic tick();
        frame_tick_i = 1'b1;
        step();
        frame_tick_i = 1'b0;
    endtask

    // Fresh press; leaves shoot_i held high. Queues a launch when one is expected.
    task automatic press(input logic [9:0] l, input logic [9:0] r, input bit expect_fire);
        shoot_i = 1'b0;
        step();
        pos_left_i  = l;
        pos_right_i = r;
        if (expect_fire) begin
            exp_x = 10'((int'(l) + int'(r)) / 2);
            exp_y = 440;
            exp_q.push_back('{1'b0, exp_x, 9'd440});
        end
        shoot_i = 1'b1;
        step();
    endtask

    // Every fired_o / miss_o cycle must match the next queued event
    always @(negedge clk_i) begin
        if (reset_n_i === 1'b1 && (fired_o === 1'b1 || miss_o === 1'b1)) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_event: fired_o=%b miss_o=%b x=%0d y=%0d, required no event",
                         fired_o, miss_o, bullet_x_o, bullet_y_o);
            end else begin
                ev_mon = exp_q.pop_front();
                if (fired_o !== !ev_mon.is_miss || miss_o !== ev_mon.is_miss ||
                    bullet_x_o !== ev_mon.x || bullet_y_o !== ev_mon.y) begin
                    n_fail++;
                    $display("FAIL event_match: got fired=%b miss=%b x=%0d y=%0d, required miss=%b x=%0d y=%0d",
                             fired_o, miss_o, bullet_x_o, bullet_y_o, ev_mon.is_miss, ev_mon.x, ev_mon.y);
                end
            end
        end
    end

    task automatic test_reset();
        reset_n_i = 1'b0; frame_tick_i = 0; shoot_i = 1; pause_i = 0; alive_i = 1;
        target_hit_i = 0; pos_left_i = 0; pos_right_i = 0;
        step(); step();
        n_checks++;
        if (state_o !== S_IDLE || bullet_active_o !== 0 || bullet_x_o !== 0 ||
            bullet_y_o !== 9'd440 || fired_o !== 0 || miss_o !== 0) begin
            n_fail++;
            $display("FAIL reset_values: state=%b act=%b x=%0d y=%0d fired=%b miss=%b, required 001 0 0 440 0 0",
                     state_o, bullet_active_o, bullet_x_o, bullet_y_o, fired_o, miss_o);
        end
        reset_n_i = 1'b1;
        repeat (3) step();
        n_checks++;
        if (state_o !== S_IDLE || bullet_active_o !== 0) begin
            n_fail++;
            $display("FAIL held_through_reset: state=%b act=%b, required 001 0", state_o, bullet_active_o);
        end
        press(10'd100, 10'd131, 1'b1);
        n_checks++;
        if (fired_o !== 1 || bullet_x_o !== 10'd115 || bullet_y_o !== 9'd440 ||
            state_o !== S_FLY || bullet_active_o !== 1) begin
            n_fail++;
            $display("FAIL first_fire: fired=%b x=%0d y=%0d state=%b act=%b, required 1 115 440 010 1",
                     fired_o, bullet_x_o, bullet_y_o, state_o, bullet_active_o);
        end
        step();
        n_checks++;
        if (fired_o !== 0) begin
            n_fail++;
            $display("FAIL fired_pulse_width: fired_o=%b, required 0", fired_o);
        end
    endtask

    task automatic test_miss();
        while (exp_y > 12) begin
            tick();
            exp_y -= 4;
            n_checks++;
            if (bullet_y_o !== 9'(exp_y) || bullet_active_o !== 1) begin
                n_fail++;
                $display("FAIL climb: y=%0d act=%b, required y=%0d act=1", bullet_y_o, bullet_active_o, exp_y);
            end
        end
        exp_q.push_back('{1'b1, 10'd115, 9'd12});
        tick();
        n_checks++;
        if (miss_o !== 1 || bullet_active_o !== 0 || state_o !== S_COOL) begin
            n_fail++;
            $display("FAIL top_miss: miss=%b act=%b state=%b, required 1 0 100", miss_o, bullet_active_o, state_o);
        end
        step();
        n_checks++;
        if (miss_o !== 0) begin
            n_fail++;
            $display("FAIL miss_pulse_width: miss_o=%b, required 0", miss_o);
        end
        repeat (15) tick();
        n_checks++;
        if (state_o !== S_COOL) begin
            n_fail++;
            $display("FAIL cooldown_length: state=%b after 15 ticks, required 100", state_o);
        end
        step();
        n_checks++;
        if (state_o !== S_IDLE) begin
            n_fail++;
            $display("FAIL cooldown_exit: state=%b, required 001", state_o);
        end
    endtask

    task automatic test_hit();
        press(10'd200, 10'd263, 1'b1);
        shoot_i = 1'b0;
        repeat (35) tick();
        n_checks++;
        if (bullet_y_o !== 9'd300) begin
            n_fail++;
            $display("FAIL hit_setup_y: y=%0d, required 300", bullet_y_o);
        end
        target_hit_i = 1'b1;
        tick();
        target_hit_i = 1'b0;
        n_checks++;
        if (bullet_active_o !== 0 || miss_o !== 0 || state_o !== S_COOL || bullet_y_o !== 9'd300 ||
            bullet_x_o !== 10'd231) begin
            n_fail++;
            $display("FAIL hit_with_tick: act=%b miss=%b state=%b x=%0d y=%0d, required 0 0 100 231 300",
                     bullet_active_o, miss_o, state_o, bullet_x_o, bullet_y_o);
        end
        repeat (15) tick();
        step();
    endtask

    task automatic test_back_to_back();
        press(10'd0, 10'd1023, 1'b1);
        repeat (3) tick();
        shoot_i = 1'b0; step();
        shoot_i = 1'b1; step();
        n_checks++;
        if (state_o !== S_FLY || fired_o !== 0 || bullet_y_o !== 9'd428) begin
            n_fail++;
            $display("FAIL fire_in_flight: state=%b fired=%b y=%0d, required 010 0 428", state_o, fired_o, bullet_y_o);
        end
        target_hit_i = 1'b1; step(); target_hit_i = 1'b0;
        shoot_i = 1'b0; step();
        shoot_i = 1'b1; step();
        n_checks++;
        if (state_o !== S_COOL || fired_o !== 0) begin
            n_fail++;
            $display("FAIL fire_in_cooldown: state=%b fired=%b, required 100 0", state_o, fired_o);
        end
        repeat (15) tick();
        step(); step();
        n_checks++;
        if (state_o !== S_IDLE || bullet_active_o !== 0) begin
            n_fail++;
            $display("FAIL held_no_refire: state=%b act=%b, required 001 0", state_o, bullet_active_o);
        end
        press(10'd1023, 10'd1023, 1'b1);
        n_checks++;
        if (fired_o !== 1 || bullet_x_o !== 10'd1023 || state_o !== S_FLY) begin
            n_fail++;
            $display("FAIL fresh_fire_wide_x: fired=%b x=%0d state=%b, required 1 1023 010",
                     fired_o, bullet_x_o, state_o);
        end
        shoot_i = 1'b0;
    endtask

    task automatic test_pause();
        repeat (60) tick();
        pause_i = 1'b1;
        repeat (10) tick();
        target_hit_i = 1'b1; step(); target_hit_i = 1'b0;
        step();
        n_checks++;
        if (bullet_y_o !== 9'd200 || bullet_active_o !== 1 || state_o !== S_FLY) begin
            n_fail++;
            $display("FAIL pause_freeze: y=%0d act=%b state=%b, required 200 1 010",
                     bullet_y_o, bullet_active_o, state_o);
        end
        pause_i = 1'b0;
        tick();
        n_checks++;
        if (bullet_y_o !== 9'd196) begin
            n_fail++;
            $display("FAIL pause_resume: y=%0d, required 196", bullet_y_o);
        end
        target_hit_i = 1'b1; step(); target_hit_i = 1'b0;
        pause_i = 1'b1;
        repeat (20) tick();
        pause_i = 1'b0;
        step();
        n_checks++;
        if (state_o !== S_COOL) begin
            n_fail++;
            $display("FAIL pause_cooldown: state=%b, required 100", state_o);
        end
    endtask

    task automatic test_alive();
        alive_i = 1'b0; step();
        n_checks++;
        if (state_o !== S_IDLE || bullet_active_o !== 0 || miss_o !== 0) begin
            n_fail++;
            $display("FAIL dead_in_cooldown: state=%b act=%b miss=%b, required 001 0 0", state_o, bullet_active_o, miss_o);
        end
        alive_i = 1'b1;
        press(10'd100, 10'd131, 1'b1);
        tick(); tick();
        alive_i = 1'b0; step();
        n_checks++;
        if (state_o !== S_IDLE || bullet_active_o !== 0 || miss_o !== 0) begin
            n_fail++;
            $display("FAIL dead_in_flight: state=%b act=%b miss=%b, required 001 0 0", state_o, bullet_active_o, miss_o);
        end
        press(10'd300, 10'd400, 1'b0);
        n_checks++;
        if (state_o !== S_IDLE || fired_o !== 0 || bullet_active_o !== 0) begin
            n_fail++;
            $display("FAIL dead_fire_ignored: state=%b fired=%b act=%b, required 001 0 0",
                     state_o, fired_o, bullet_active_o);
        end
        alive_i = 1'b1; shoot_i = 1'b0; step();
    endtask

    task automatic test_async_reset();
        press(10'd100, 10'd131, 1'b1);
        tick(); tick();
        #2 reset_n_i = 1'b0;
        #1;
        n_checks++;
        if (state_o !== S_IDLE || bullet_active_o !== 0 || bullet_y_o !== 9'd440 || bullet_x_o !== 0) begin
            n_fail++;
            $display("FAIL async_reset: state=%b act=%b x=%0d y=%0d, required 001 0 0 440",
                     state_o, bullet_active_o, bullet_x_o, bullet_y_o);
        end
        step();
        reset_n_i = 1'b1;
        step(); step();
        n_checks++;
        if (state_o !== S_IDLE || fired_o !== 0) begin
            n_fail++;
            $display("FAIL post_reset_held: state=%b fired=%b, required 001 0", state_o, fired_o);
        end
    endtask

    initial begin
        test_reset();
        test_miss();
        test_hit();
        test_back_to_back();
        test_pause();
        test_alive();
        test_async_reset();
        repeat (2) step();
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: %0d events still pending, required 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
